// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

   // op[1] selects divide, op[0] selects signed
   localparam logic [1:0] OP_MULU = 2'b00;
   localparam logic [1:0] OP_MULS = 2'b01;
   localparam logic [1:0] OP_DIVU = 2'b10;
   localparam logic [1:0] OP_DIVS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the double-width accumulator.
// Multiply: acc = {partial_hi, multiplier_lo}; conditional add then shift right.
// Divide:   acc = {remainder, dividend/quotient}; shift left, trial subtract, restore.
module muldiv_step #(
   parameter int WIDTH = 16
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [2*WIDTH:0] sh;
   logic [WIDTH:0]   diff;

   // single add-shift or subtract-restore step
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      sh       = {acc, 1'b0};
      diff     = sh[2*WIDTH:WIDTH] - {1'b0, opnd};
      acc_next = '0;
      if (!is_div)
         acc_next = {sum, acc[WIDTH-1:1]};
      else if (!diff[WIDTH])
         acc_next = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
      else
         acc_next = sh[2*WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. Operates on magnitudes and
// applies signs in a fixup cycle; double-width result goes out as lo/hi.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc, acc_step, prod;
   logic [WIDTH-1:0]   opnd, quo, rem, fix_lo, fix_hi;
   logic [CW-1:0]      count;
   logic               is_div, neg_q, neg_r, ovf_pend;
   logic               signed_op, sign_a, sign_b, launch, dbz_in;
   logic [WIDTH-1:0]   abs_a, abs_b;

   // operand conditioning at launch (magnitudes, signs, early exits)
   always_comb begin
      signed_op = SIGNED_EN && op[0];
      sign_a    = signed_op & in_a[WIDTH-1];
      sign_b    = signed_op & in_b[WIDTH-1];
      abs_a     = sign_a ? -in_a : in_a;
      abs_b     = sign_b ? -in_b : in_b;
      launch    = start & ~flush & (state == ST_IDLE);
      dbz_in    = op[1] & (in_b == '0);
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .opnd     (opnd),
      .acc_next (acc_step)
   );

   // sign fixup of the finished magnitudes; MIN/-1 falls out as MIN naturally
   always_comb begin
      prod   = neg_q ? -acc : acc;
      quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = is_div ? quo : prod[WIDTH-1:0];
      fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
   end

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; flush overrides everything
   always_comb begin
      state_nxt = state;
      if (flush) state_nxt = ST_IDLE;
      else begin
         case (state)
            ST_IDLE:  if (start) state_nxt = dbz_in ? ST_DONE : ST_CALC;
            ST_CALC:  if (count == '0) state_nxt = ST_FIXUP;
            ST_FIXUP: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      stall_req = (start & (state == ST_IDLE) & ~flush) | (busy & (state != ST_DONE));
   end

   // datapath: load at launch, iterate in CALC, publish results entering DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc         <= '0;
         opnd        <= '0;
         count       <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         ovf_pend    <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         div_by_zero <= 1'b0;
         ovf         <= 1'b0;
      end else if (launch) begin
         opnd     <= op[1] ? abs_b : abs_a;
         acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
         count    <= CW'(WIDTH - 1);
         is_div   <= op[1];
         neg_q    <= sign_a ^ sign_b;
         neg_r    <= sign_a;
         ovf_pend <= signed_op & op[1] & (in_a == MIN_VAL) & (in_b == '1);
         if (dbz_in) begin
            result_lo   <= '1;
            result_hi   <= in_a;
            div_by_zero <= 1'b1;
            ovf         <= 1'b0;
         end
      end else if (!flush && state == ST_CALC) begin
         acc   <= acc_step;
         count <= count - 1'b1;
      end else if (!flush && state == ST_FIXUP) begin
         result_lo   <= fix_lo;
         result_hi   <= fix_hi;
         div_by_zero <= 1'b0;
         ovf         <= ovf_pend;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=16): directed literal cases plus randomized
// traffic against a cycle-count/arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op    = 2'b00;
   logic          flush = 1'b0;
   logic [W-1:0]  in_a  = '0;
   logic [W-1:0]  in_b  = '0;
   logic          busy, stall_req, done, div_by_zero, ovf;
   logic [W-1:0]  result_lo, result_hi;

   int n_total = 0;
   int n_pass  = 0;

   muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .flush       (flush),
      .in_a        (in_a),
      .in_b        (in_b),
      .busy        (busy),
      .stall_req   (stall_req),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .div_by_zero (div_by_zero),
      .ovf         (ovf)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // arithmetic reference: what the operation must produce and when
   function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz, output logic ov, output int tgt);
      longint      sa, sb, ua, ub, q, r;
      logic [63:0] pv;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'(a);          ub = longint'(b);
      dz = 1'b0; ov = 1'b0; tgt = W + 2;
      lo = '0; hi = '0;
      if (o[1] && b == '0) begin
         lo = '1; hi = a; dz = 1'b1; tgt = 1;
      end else if (!o[1]) begin
         pv = o[0] ? 64'(sa * sb) : 64'(ua * ub);
         lo = pv[15:0]; hi = pv[31:16];
      end else begin
         if (o[0]) begin q = sa / sb; r = sa % sb; end
         else      begin q = ua / ub; r = ua % ub; end
         pv = 64'(q); lo = pv[15:0];
         pv = 64'(r); hi = pv[15:0];
         ov = o[0] && a == 16'h8000 && b == 16'hFFFF;
      end
   endfunction

   // model state: busy flag, cycles since start, target done cycle, held outputs
   logic         m_busy;
   int           m_cnt, m_tgt;
   logic [W-1:0] m_lo, m_hi, p_lo, p_hi, t_lo, t_hi;
   logic         m_dz, m_ov, p_dz, p_ov, t_dz, t_ov;
   int           t_tgt;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_cnt <= 0; m_tgt <= 0;
         m_lo <= '0; m_hi <= '0; m_dz <= 1'b0; m_ov <= 1'b0;
         p_lo <= '0; p_hi <= '0; p_dz <= 1'b0; p_ov <= 1'b0;
      end else if (m_busy) begin
         if (flush || m_cnt == m_tgt) m_busy <= 1'b0;
         else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_tgt) begin
               m_lo <= p_lo; m_hi <= p_hi; m_dz <= p_dz; m_ov <= p_ov;
            end
         end
      end else if (start && !flush) begin
         ref_op(op, in_a, in_b, t_lo, t_hi, t_dz, t_ov, t_tgt);
         m_busy <= 1'b1; m_cnt <= 1; m_tgt <= t_tgt;
         p_lo <= t_lo; p_hi <= t_hi; p_dz <= t_dz; p_ov <= t_ov;
         if (t_tgt == 1) begin
            m_lo <= t_lo; m_hi <= t_hi; m_dz <= t_dz; m_ov <= t_ov;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clock) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_busy && m_cnt == m_tgt));
      chk("stall_req", 32'(stall_req),
          32'((start && !m_busy && !flush) || (m_busy && m_cnt != m_tgt)));
      chk("result_lo", 32'(result_lo), 32'(m_lo));
      chk("result_hi", 32'(result_hi), 32'(m_hi));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
      chk("ovf", 32'(ovf), 32'(m_ov));
   end

   // called at posedge+1 with the unit idle; optional junk start at cycle poke
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke, output int lat,
                        output logic [W-1:0] lo, output logic [W-1:0] hi,
                        output logic dz, output logic ov);
      start = 1'b1; op = o; in_a = a; in_b = b;
      lat = -1; lo = '0; hi = '0; dz = 1'b0; ov = 1'b0;
      @(posedge clock); #1;
      start = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
      for (int c = 1; c < 40; c++) begin
         if (c == poke) begin start = 1'b1; op = 2'b10; in_b = '0; end
         @(negedge clock);
         if (done) begin
            lat = c; lo = result_lo; hi = result_hi; dz = div_by_zero; ov = ovf;
         end
         @(posedge clock); #1;
         start = 1'b0;
         if (lat >= 0) break;
      end
      if (lat < 0) chk("done_timeout", 32'(lat), 32'(0));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return W'($urandom_range(0, 7));
         default: return W'($urandom);
      endcase
   endfunction

   int           lat;
   logic [W-1:0] lo, hi;
   logic         dz, ov, seen;

   initial begin
      #1;
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_lo", 32'(result_lo), 32'(0));
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      do_op(2'b00, 16'h00FF, 16'h0101, 0, lat, lo, hi, dz, ov);
      chk("mulu_lat", 32'(lat), 32'd18);
      chk("mulu_lo", 32'(lo), 32'hFFFF);
      chk("mulu_hi", 32'(hi), 32'h0000);

      do_op(2'b01, 16'hFFFE, 16'h0003, 0, lat, lo, hi, dz, ov);
      chk("muls_lo", 32'(lo), 32'hFFFA);
      chk("muls_hi", 32'(hi), 32'hFFFF);

      do_op(2'b10, 16'd100, 16'd7, 0, lat, lo, hi, dz, ov);
      chk("divu_lo", 32'(lo), 32'h000E);
      chk("divu_hi", 32'(hi), 32'h0002);

      do_op(2'b11, 16'hFFF9, 16'h0002, 0, lat, lo, hi, dz, ov);
      chk("divs_lo", 32'(lo), 32'hFFFD);
      chk("divs_hi", 32'(hi), 32'hFFFF);

      do_op(2'b11, 16'h8000, 16'hFFFF, 0, lat, lo, hi, dz, ov);
      chk("ovf_lat", 32'(lat), 32'd18);
      chk("ovf_lo", 32'(lo), 32'h8000);
      chk("ovf_hi", 32'(hi), 32'h0000);
      chk("ovf_flag", 32'(ov), 32'd1);

      do_op(2'b10, 16'h1234, 16'h0000, 0, lat, lo, hi, dz, ov);
      chk("dbz_lat", 32'(lat), 32'd1);
      chk("dbz_lo", 32'(lo), 32'hFFFF);
      chk("dbz_hi", 32'(hi), 32'h1234);
      chk("dbz_flag", 32'(dz), 32'd1);

      // start while busy is ignored: MULU completes with its own result
      do_op(2'b00, 16'h0003, 16'h0005, 3, lat, lo, hi, dz, ov);
      chk("ign_lat", 32'(lat), 32'd18);
      chk("ign_lo", 32'(lo), 32'h000F);
      chk("ign_dbz", 32'(dz), 32'd0);

      // flush at cycle 5 of a MULU
      start = 1'b1; op = 2'b00; in_a = 16'h1111; in_b = 16'h2222;
      @(posedge clock); #1 start = 1'b0;
      repeat (4) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock); #1 flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_lo_held", 32'(result_lo), 32'h000F);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin @(negedge clock); seen |= done; end
      chk("flush_no_done", 32'(seen), 32'd0);
      @(posedge clock); #1;

      // start and flush together
      start = 1'b1; flush = 1'b1; op = 2'b10; in_b = '0;
      @(posedge clock); #1 start = 1'b0; flush = 1'b0;
      chk("startflush_idle", 32'(busy), 32'd0);

      // reset at cycle 9 of a DIVU
      start = 1'b1; op = 2'b10; in_a = 16'd500; in_b = 16'd3;
      @(posedge clock); #1 start = 1'b0;
      repeat (8) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_lo", 32'(result_lo), 32'd0);
      chk("rst_hi", 32'(result_hi), 32'd0);
      @(posedge clock); #1 reset = 1'b1;

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         op    = 2'($urandom);
         in_a  = pick();
         in_b  = pick();
         flush = ($urandom_range(0, 39) == 0);
         @(posedge clock); #1;
      end
      start = 1'b0; flush = 1'b0;
      repeat (25) @(posedge clock);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
